mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported mem_system-style backend between the instruction-fetch port and the data (EX/MEM) port of the pipeline, so a unified memory can serve both.
- Arbitrates between the two ports, latches the winning request, and holds the backend command until the backend signals done.
- Returns data, done and stall signals to each port.
- Sits between the fetch/memory pipeline stages and the single memory instance.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants made while a fetch request is waiting; the next arbitration must then grant fetch.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request; held high until i_done.
- i_addr  in  AW  fetch address.
- i_cancel  in  1  fetch squash (branch taken); a fetch in flight completes but its i_done is suppressed.
- i_data  out  DW  fetch read data; valid when i_done=1.
- i_done  out  1  one-cycle fetch completion pulse.
- i_stall  out  1  i_req & ~i_done.
- d_rd  in  1  data read request; held until d_done.
- d_wr  in  1  data write request; held until d_done.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_data  out  DW  read data; valid when d_done=1.
- d_done  out  1  one-cycle data completion pulse.
- d_stall  out  1  (d_rd|d_wr) & ~d_done.
- mem_rd  out  1  backend read strobe.
- mem_wr  out  1  backend write strobe.
- mem_addr  out  AW  backend address.
- mem_wdata  out  DW  backend write data.
- mem_rdata  in  DW  backend read data.
- mem_done  in  1  backend completion pulse.
- mem_err  in  1  backend error.
- err  out  1  sticky error flag.

Behaviour:
- States: IDLE, BUSY_D, BUSY_I. Reset (rst=0, asynchronous) forces:
  - state=IDLE, starve_cnt=0, err=0;
  - all latched address/data registers=0;
  - mem_rd, mem_wr, i_done and d_done=0 immediately, including when reset lands mid-transaction. The interrupted transaction is dropped and no done pulse is issued.
- IDLE arbitration, evaluated at each rising edge:
  - Data request (d_rd|d_wr) wins over i_req, unless starve_cnt==STARVE_MAX and i_req=1; fetch then wins.
  - A fetch with i_cancel=1 in the arbitration cycle is not granted.
- On a grant:
  - latch the address (and write data plus the rd/wr kind for data);
  - go to BUSY_D or BUSY_I.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on each data grant made while i_req=1;
  - clears on any fetch grant;
  - holds otherwise.
- In a BUSY state:
  - mem_rd or mem_wr is held at 1 from the latched kind (fetch is always a read);
  - mem_addr and mem_wdata are driven from the latches and stay stable for the whole transaction. Requester inputs may change without effect.
- mem_done=1 in BUSY_D:
  - d_done=1 in that same cycle, with d_data=mem_rdata;
  - mem_rd/mem_wr drop in the next cycle and the state returns to IDLE.
- mem_done=1 in BUSY_I:
  - i_done=1 in that cycle unless a cancel was latched; i_data=mem_rdata;
  - state returns to IDLE.
- Cancel latch: i_cancel=1 at any cycle of BUSY_I sets a cancel flag, which is cleared on leaving BUSY_I. A new fetch needs a fresh arbitration.
- Latency: request seen in IDLE at edge n → strobe from cycle n+1 → done in the cycle mem_done arrives. There is at least one IDLE cycle between transactions.
- d_rd=d_wr=1 in the arbitration cycle: set err and treat the request as a write.
- mem_err=1 in any BUSY cycle sets err. err is sticky until reset.
- Outside IDLE with mem_done=0, i_done and d_done are 0. mem_rd and mem_wr are never both 1.
- i_data and d_data hold their last completed value between completions.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, BUSY_D=2'b01, BUSY_I=2'b10), AW/DW defaults, STARVE_MAX default.
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clr/sat outputs, instanced once.

Test Plan:
- Reset mid BUSY_D (mem_wr=1): drive rst=0 → mem_wr=0 asynchronously, state IDLE, no d_done, err=0.
- Data read alone: d_rd=1, d_addr=16'h0040, mem_done 3 cycles later with mem_rdata=16'hBEEF → mem_rd held 3 cycles with mem_addr=0040; d_done pulses once with d_data=BEEF.
- Simultaneous i_req and d_wr (addr 16'h0010, data 16'h1234) → data granted first, mem_wr with wdata 1234; fetch granted after d_done plus one IDLE cycle.
- Starvation with STARVE_MAX=4: i_req held, d_rd re-asserted every cycle → after 4 data grants the 5th grant goes to fetch; starve_cnt returns to 0.
- i_cancel pulsed during BUSY_I → mem_rd continues until mem_done; i_done stays 0; next i_req is re-arbitrated.
- d_rd=d_wr=1 → err=1 and a write is issued; separately, mem_err pulse in BUSY_I → err=1, held until rst.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding and
// default widths/limits.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_D = 2'b01,
        BUSY_I = 2'b10
    } arbState_e;

    localparam int AW_DEFAULT         = 16;
    localparam int DW_DEFAULT         = 16;
    localparam int STARVE_MAX_DEFAULT = 4;

    function automatic int ctrWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter tracking consecutive data grants made while a fetch
// is waiting; clr has priority over inc.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = ctrWidth(MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(MAX))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory backend between the instruction-fetch
// port and the data port, holding the latched command until mem_done.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate on each rising edge
//   BUSY_D | data read/write in flight, strobe held until mem_done
//   BUSY_I | fetch read in flight, strobe held until mem_done
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = AW_DEFAULT,
    parameter int DW         = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic [DW-1:0] i_data,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_data,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    input  logic          mem_err,
    output logic          err
);

    arbState_e state, nextState;

    logic          dataReq;
    logic          fetchEligible;
    logic          starveSat;
    logic          grantD;
    logic          grantI;
    logic          busy;
    logic          dComplete;
    logic          iComplete;
    logic          latWrite;
    logic          cancelFlag;
    logic [AW-1:0] latAddr;
    logic [DW-1:0] latWdata;
    logic [DW-1:0] dDataHold;
    logic [DW-1:0] iDataHold;

    assign dataReq       = d_rd | d_wr;
    assign fetchEligible = i_req & ~i_cancel;
    assign busy          = (state == BUSY_D) || (state == BUSY_I);

    // Data normally wins; a saturated starve count hands the slot to fetch.
    assign grantI = (state == IDLE) && fetchEligible && (!dataReq || starveSat);
    assign grantD = (state == IDLE) && dataReq && !grantI;

    assign dComplete = (state == BUSY_D) && mem_done;
    assign iComplete = (state == BUSY_I) && mem_done;

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starveCtr (
        .clk(clk),
        .rst(rst),
        .inc(grantD && i_req),
        .clr(grantI),
        .sat(starveSat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantD) begin
                    nextState = BUSY_D;
                end else if (grantI) begin
                    nextState = BUSY_I;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_done) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latAddr    <= '0;
            latWdata   <= '0;
            latWrite   <= 1'b0;
            cancelFlag <= 1'b0;
            err        <= 1'b0;
            dDataHold  <= '0;
            iDataHold  <= '0;
        end else begin
            if (grantD) begin
                latAddr  <= d_addr;
                latWdata <= d_wdata;
                latWrite <= d_wr;
            end else if (grantI) begin
                latAddr  <= i_addr;
                latWrite <= 1'b0;
            end

            if (state == BUSY_I) begin
                cancelFlag <= (cancelFlag | i_cancel) & ~mem_done;
            end else begin
                cancelFlag <= 1'b0;
            end

            if ((grantD && d_rd && d_wr) || (busy && mem_err)) begin
                err <= 1'b1;
            end

            if (dComplete) begin
                dDataHold <= mem_rdata;
            end
            if (iComplete) begin
                iDataHold <= mem_rdata;
            end
        end
    end

    // Strobes decode straight from state so reset kills them immediately.
    assign mem_rd    = ((state == BUSY_D) && !latWrite) || (state == BUSY_I);
    assign mem_wr    = (state == BUSY_D) && latWrite;
    assign mem_addr  = latAddr;
    assign mem_wdata = latWdata;

    assign d_done  = dComplete;
    assign d_data  = dComplete ? mem_rdata : dDataHold;
    assign d_stall = dataReq & ~d_done;

    // A squash arriving in the completion cycle itself also suppresses i_done.
    assign i_done  = iComplete && !cancelFlag && !i_cancel;
    assign i_data  = iComplete ? mem_rdata : iDataHold;
    assign i_stall = i_req & ~i_done;

endmodule
